// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and baud counter sizing, common to the
// transmitter and receiver.
package uart_pkg;

    localparam int unsigned BaudCntWidth         = 14;
    localparam int unsigned DefaultBaudTickCount = 10416;

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StStart = 3'b001,
        StData  = 3'b010,
        StStop  = 3'b011
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-bit two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module uart_rx_sync #(
    parameter int unsigned     Width      = 1,
    parameter logic [Width-1:0] ResetValue = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre-sampled data, stop-bit check,
// and a valid/ack holding register with framing-error and overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_TICK_COUNT = DefaultBaudTickCount,
    parameter int unsigned HALF_TICK_COUNT = BAUD_TICK_COUNT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [BaudCntWidth-1:0] BaudTerm = BaudCntWidth'(BAUD_TICK_COUNT);
    localparam logic [BaudCntWidth-1:0] HalfTerm = BaudCntWidth'(HALF_TICK_COUNT);

    logic rx_s;

    uart_rx_sync #(
        .Width      (1),
        .ResetValue (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    uart_state_e             state_q, state_d;
    logic [BaudCntWidth-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [7:0]              shift_q, shift_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_err_q, frame_err_d;
    logic                    commit;

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + BaudCntWidth'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_cnt_q == HalfTerm) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    // A line that has returned high by mid-bit was a glitch.
                    state_d    = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (baud_cnt_q == BaudTerm) begin
                    baud_cnt_d         = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (baud_cnt_q == BaudTerm) begin
                    baud_cnt_d = '0;
                    state_d    = StIdle;
                    if (rx_s) begin
                        commit = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = '0;
            end
        endcase

        if (commit) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk/bit (BAUD_TICK_COUNT=15, HALF_TICK_COUNT=7).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int rise_cyc;
    int fe_cnt;
    int fe_cyc;

    // rx_valid commit edge: 2 + (7+1) + 9*16 + 1 = 155 cycles after the falling edge.
    localparam int Latency = 155;

    uart_rx #(
        .BAUD_TICK_COUNT (15),
        .HALF_TICK_COUNT (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drives one 10-bit frame, as the companion transmitter would, and records output events.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        logic       prev_valid;
        frame      = {stop_bit, data, 1'b0};
        prev_valid = rx_valid;
        rise_cyc   = -1;
        fe_cnt     = 0;
        fe_cyc     = -1;
        for (int c = 0; c < 160; c++) begin
            rx = frame[c/16];
            tick();
            if (rise_cyc < 0 && prev_valid !== 1'b1 && rx_valid === 1'b1) rise_cyc = c + 1;
            if (frame_err === 1'b1) begin
                fe_cnt++;
                fe_cyc = c + 1;
            end
        end
        rx = 1'b1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL %s outputs got data=%h v=%b b=%b fe=%b ov=%b exp all zero", tag,
                     rx_data, rx_valid, rx_busy, frame_err, overrun);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        idle(5);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1);
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++; $display("FAIL basic_data got %h exp a5", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid got %b exp 1", rx_valid);
        end
        checks++;
        if (rise_cyc < Latency - 1 || rise_cyc > Latency + 1) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d+-1", rise_cyc, Latency);
        end
        checks++;
        if (fe_cnt != 0) begin
            errors++; $display("FAIL basic_frame_err got %0d pulses exp 0", fe_cnt);
        end
        do_ack();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL basic_ack got valid=%b exp 0", rx_valid);
        end
        idle(10);
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        int fe_seen  = 0;
        for (int c = 0; c < 33; c++) begin
            rx = (c < 3) ? 1'b0 : 1'b1;
            tick();
            if (rx_busy === 1'b1) busy_cnt++;
            if (frame_err === 1'b1) fe_seen++;
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++; $display("FAIL glitch_busy got %0d cycles exp 8", busy_cnt);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL glitch_idle got busy=%b exp 0", rx_busy);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
            errors++; $display("FAIL glitch_hold got v=%b data=%h exp v=0 data=a5", rx_valid, rx_data);
        end
        checks++;
        if (fe_seen != 0) begin
            errors++; $display("FAIL glitch_frame_err got %0d exp 0", fe_seen);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0);
        checks++;
        if (fe_cnt != 1) begin
            errors++; $display("FAIL ferr_pulses got %0d exp 1", fe_cnt);
        end
        checks++;
        if (fe_cyc < Latency - 1 || fe_cyc > Latency + 1) begin
            errors++; $display("FAIL ferr_timing got %0d exp %0d+-1", fe_cyc, Latency);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
            errors++; $display("FAIL ferr_hold got v=%b data=%h exp v=0 data=a5", rx_valid, rx_data);
        end
        idle(40);
        checks++;
        if (rx_busy !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL ferr_settle got b=%b fe=%b exp 0 0", rx_busy, frame_err);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1);
        checks++;
        if (rx_data !== 8'h11 || overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_first got data=%h ov=%b exp 11 0", rx_data, overrun);
        end
        send_frame(8'h22, 1'b1);
        checks++;
        if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second got data=%h v=%b exp 22 1", rx_data, rx_valid);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL b2b_overrun got %b exp 1", overrun);
        end
        idle(4);
        do_ack();
        checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_ack got v=%b ov=%b exp 0 0", rx_valid, overrun);
        end
        do_ack();
        checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0 || rx_data !== 8'h22) begin
            errors++; $display("FAIL idle_ack got v=%b ov=%b data=%h exp 0 0 22", rx_valid,
                               overrun, rx_data);
        end
        idle(10);
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'hF0, 1'b0};
        // Start bit, data bits 0..3, then half of bit 4.
        for (int c = 0; c < 88; c++) begin
            rx = frame[c/16];
            tick();
        end
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy got %b exp 1", rx_busy);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("rstmid");
        tick();
        tick();
        rst = 1'b0;
        idle(20);
        check_idle_outputs("rstmid_idle");
        send_frame(8'h5A, 1'b1);
        checks++;
        if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_recv got data=%h v=%b exp 5a 1", rx_data, rx_valid);
        end
        checks++;
        if (rise_cyc < Latency - 1 || rise_cyc > Latency + 1) begin
            errors++; $display("FAIL rstmid_latency got %0d exp %0d+-1", rise_cyc, Latency);
        end
        do_ack();
        idle(10);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            send_frame(bytes[i], 1'b1);
            checks++;
            if (rx_data !== bytes[i] || rx_valid !== 1'b1) begin
                errors++; $display("FAIL loop_data%0d got %h v=%b exp %h 1", i, rx_data, rx_valid,
                                   bytes[i]);
            end
            checks++;
            if (fe_cnt != 0 || overrun !== 1'b0) begin
                errors++; $display("FAIL loop_flags%0d got fe=%0d ov=%b exp 0 0", i, fe_cnt, overrun);
            end
            do_ack();
            checks++;
            if (rx_valid !== 1'b0) begin
                errors++; $display("FAIL loop_ack%0d got v=%b exp 0", i, rx_valid);
            end
            idle(3);
        end
    endtask

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
